// File: rtl/serial_add_pkg.sv
// ----------------------------------------------------------------------------
// serial_add_pkg
// Shared constants for the bit-serial adder controller:
//   IDLE / SHIFT / DONE : 2-bit controller state encodings
//   MAX_WIDTH           : largest supported operand width
//   cnt_width()         : width of the bit counter for a given operand width
// ----------------------------------------------------------------------------
package serial_add_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int MAX_WIDTH = 32;

  // ceil(log2(width)) with a floor of 1, so WIDTH=1 still gets a 1-bit counter.
  function automatic int cnt_width(input int width);
    int cw;
    cw = 1;
    for (int i = 1; i <= $clog2(MAX_WIDTH); i++) begin
      if ((32'd1 << i) < width) cw = i + 1;
    end
    return cw;
  endfunction

endpackage

// File: rtl/fa_bit.sv
// ----------------------------------------------------------------------------
// fa_bit
// Single-bit full adder built from two half adders; the adder cell that the
// serial controller sequences once per bit.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
// ----------------------------------------------------------------------------
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic s1;
  logic c1;
  logic c2;

  ha u_ha0 (.a(a),  .b(b),  .s(s1), .c(c1));
  ha u_ha1 (.a(s1), .b(ci), .s(s),  .c(c2));

  // At most one of the two half-adder carries can be set, so OR merges them.
  assign co = c1 | c2;

endmodule

// File: rtl/ha.sv
// ----------------------------------------------------------------------------
// ha
// Combinational half adder.
//   a, b : input bits
//   s    : sum  (a ^ b)
//   c    : carry (a & b)
// ----------------------------------------------------------------------------
module ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial adder: {cout,sum} = a + b + cin, computed LSB first through one
// shared fa_bit over WIDTH clock cycles.
//   clk   : rising-edge clock
//   rst   : synchronous, active-high reset
//   start : begin an add (only looked at in IDLE)
//   a, b  : operands, captured on the accepting edge
//   cin   : carry-in, captured on the accepting edge
//   busy  : high while bits are being shifted through the adder
//   done  : one-cycle pulse, sum/cout valid
//   sum   : result, held until the next completion
//   cout  : final carry-out, held with sum
// ----------------------------------------------------------------------------
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q,  a_sh_d;
  logic [WIDTH-1:0] b_sh_q,  b_sh_d;
  logic [WIDTH-1:0] s_sh_q,  s_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] s_next;

  fa_bit u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
  // Written as a shift of the concatenation so WIDTH=1 needs no special case.
  assign s_next = WIDTH'({fa_s, s_sh_q} >> 1);

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case
    // leaves one unassigned and no latch is inferred.
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          s_sh_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        s_sh_d  = s_next;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          sum_d   = s_next;
          cout_d  = fa_co;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// ----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=1. Expected
// results come from plain arithmetic (a + b + cin) and from the documented
// handshake timing (done WIDTH edges after the accepting edge).
// ----------------------------------------------------------------------------
module tb_serial_add_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       busy1;
  logic       done1;
  logic [0:0] sum1;
  logic       cout1;

  int n_checks;
  int n_pass;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // One rising edge, then settle; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain unsigned addition into WIDTH+1 bits.
  function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return 9'(x) + 9'(y) + 9'(c);
  endfunction

  // Accept one op, scramble the inputs afterwards, wait for done (bounded),
  // and check latency, busy length, result and result hold.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        input string tag);
    logic [8:0] exp;
    int lat;
    int nbusy;
    int overlap;
    exp   = ref_add8(ta, tb_v, tc);
    a     = ta;
    b     = tb_v;
    cin   = tc;
    start = 1'b1;
    tick();
    start = 1'b0;
    a     = 8'($urandom);
    b     = 8'($urandom);
    cin   = 1'($urandom);
    lat     = 0;
    nbusy   = 0;
    overlap = 0;
    while (!done && lat < 100) begin
      if (busy) nbusy++;
      tick();
      lat++;
    end
    if (busy && done) overlap = 1;
    check({tag, " latency"},   64'(lat),   64'(8));
    check({tag, " busy_len"},  64'(nbusy), 64'(8));
    check({tag, " overlap"},   64'(overlap), 64'(0));
    check({tag, " result"},    64'({cout, sum}), 64'(exp));
    tick();
    check({tag, " done_drop"}, 64'(done), 64'(0));
    check({tag, " hold"},      64'({cout, sum}), 64'(exp));
  endtask

  initial begin
    int done_cnt;
    int busy_cnt;
    int both_cnt;
    int last_done;
    int gap_bad;
    logic [8:0] exp9;
    logic [1:0] exp1;

    n_checks = 0;
    n_pass   = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    cin1   = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset sum",  64'({cout, sum}), 64'(0));
    check("reset w1",   64'({busy1, done1, cout1, sum1}), 64'(0));

    // Directed operands
    run_op(8'h35, 8'h4A, 1'b0, "op35_4a");
    run_op(8'hFF, 8'h01, 1'b0, "opff_01");
    run_op(8'hFF, 8'hFF, 1'b1, "opff_ff_c");

    // start pulses during SHIFT (busy cycles 3 and 8) are ignored
    exp9  = ref_add8(8'h12, 8'h34, 1'b1);
    a     = 8'h12;
    b     = 8'h34;
    cin   = 1'b1;
    start = 1'b1;
    tick();
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (cyc == 3 || cyc == 8) begin
        start = 1'b1;
        a     = 8'($urandom);
        b     = 8'($urandom);
        cin   = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check("ignore done",   64'(done), 64'(1));
    check("ignore result", 64'({cout, sum}), 64'(exp9));
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check("ignore extra_done", 64'(done_cnt), 64'(0));
    check("ignore extra_busy", 64'(busy_cnt), 64'(0));

    // start held high: one op every WIDTH+2 edges
    a         = 8'h10;
    b         = 8'h20;
    cin       = 1'b0;
    start     = 1'b1;
    done_cnt  = 0;
    both_cnt  = 0;
    last_done = -1;
    gap_bad   = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (busy && done) both_cnt++;
      if (done) begin
        done_cnt++;
        check("held result", 64'({cout, sum}), 64'(9'h030));
        if (last_done >= 0 && (i - last_done) != 10) gap_bad++;
        last_done = i;
      end
    end
    start = 1'b0;
    check("held pulses",  64'(done_cnt), 64'(3));
    check("held gap",     64'(gap_bad),  64'(0));
    check("held overlap", 64'(both_cnt), 64'(0));
    for (int i = 0; i < 12; i++) tick();

    // Reset at busy cycle 4 aborts the op
    a     = 8'hA5;
    b     = 8'h5A;
    cin   = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("abort was_busy", 64'(busy), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", 64'(busy), 64'(0));
    check("abort done", 64'(done), 64'(0));
    check("abort sum",  64'({cout, sum}), 64'(0));
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) done_cnt++;
    end
    check("abort no_done", 64'(done_cnt), 64'(0));
    run_op(8'h01, 8'h01, 1'b0, "after_abort");

    // WIDTH=1: done immediately after the single shift edge
    for (int k = 0; k < 9; k++) begin
      if (k == 0) begin
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
      end else begin
        a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
      end
      exp1   = 2'(a1) + 2'(b1) + 2'(cin1);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      a1     = ~a1;
      check("w1 busy", 64'({busy1, done1}), 64'(2'b10));
      tick();
      check("w1 done",   64'({busy1, done1}), 64'(2'b01));
      check("w1 result", 64'({cout1, sum1}), 64'(exp1));
      tick();
      check("w1 idle", 64'({busy1, done1}), 64'(2'b00));
    end

    // Random sweep at WIDTH=8 with random idle gaps
    for (int n = 0; n < 1000; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
      run_op(8'($urandom), 8'($urandom), 1'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
